// File: rtl/tmds_pkg.sv
// Shared constants for the TMDS receive channel: control-token codes, alignment
// FSM states and the window-offset width.
package tmds_pkg;

    localparam int OFFSET_W = 4;

    localparam logic [9:0] TMDS_CTL0 = 10'b1101010100;
    localparam logic [9:0] TMDS_CTL1 = 10'b0010101011;
    localparam logic [9:0] TMDS_CTL2 = 10'b0101010100;
    localparam logic [9:0] TMDS_CTL3 = 10'b1010101011;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } tmds_state_e;

    // Window offsets run 0..9 and wrap back to 0.
    function automatic logic [OFFSET_W-1:0] next_offset(input logic [OFFSET_W-1:0] off);
        return (off == OFFSET_W'(9)) ? '0 : off + OFFSET_W'(1);
    endfunction

endpackage

// File: rtl/tmds_word_decode.sv
// Combinational TMDS character decode: 10b symbol -> 8-bit data, or 2-bit
// control value when the symbol is one of the four control tokens.
module tmds_word_decode
    import tmds_pkg::*;
(
    input  logic [9:0] q,
    output logic [7:0] data,
    output logic [1:0] c,
    output logic       is_ctl
);

    logic [7:0] d;

    always_comb begin
        d    = q[9] ? ~q[7:0] : q[7:0];
        data = '0;
        data[0] = d[0];
        // q[8] selects whether the encoder chained with XOR or XNOR.
        for (int i = 1; i < 8; i++) begin
            data[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
    end

    always_comb begin
        c      = 2'd0;
        is_ctl = 1'b1;
        case (q)
            TMDS_CTL0: c = 2'd0;
            TMDS_CTL1: c = 2'd1;
            TMDS_CTL2: c = 2'd2;
            TMDS_CTL3: c = 2'd3;
            default:   is_ctl = 1'b0;
        endcase
    end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: barrel-window word alignment locked by control-token
// runs, then 10b->8b decode. Lock-loss counter is built only with TMDS_ERR_CNT_EN.
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_RUN       = 8,
    parameter int SEARCH_TIMEOUT = 1024,
    parameter int LOSS_TIMEOUT   = 4096
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [9:0]          din,
    output logic [7:0]          data,
    output logic [1:0]          c,
    output logic                de,
    output logic                locked,
    output logic [OFFSET_W-1:0] offset
`ifdef TMDS_ERR_CNT_EN
    ,
    input  logic                err_clr,
    output logic [15:0]         err_cnt
`endif
);

    localparam int RUN_W  = $clog2(LOCK_RUN) + 1;
    localparam int TMO_W  = $clog2(SEARCH_TIMEOUT) + 1;
    localparam int LOSS_W = $clog2(LOSS_TIMEOUT) + 1;

    localparam logic [RUN_W-1:0]  RUN_FULL  = RUN_W'(LOCK_RUN);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(SEARCH_TIMEOUT - 1);
    localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_TIMEOUT - 1);
    localparam logic [1:0]        HOLDOFF   = 2'd2;

    logic [9:0]          din_q, din_d;
    logic [9:0]          s1_q, s1_d;
    logic [7:0]          data_q, data_d;
    logic [1:0]          c_q, c_d;
    logic                de_q, de_d;
    tmds_state_e         state_q, state_d;
    logic [OFFSET_W-1:0] offset_q, offset_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [LOSS_W-1:0]   loss_q, loss_d;
    logic [1:0]          hold_q, hold_d;

    logic [7:0]          dec_data;
    logic [1:0]          dec_c;
    logic                dec_ctl;

    // Window over {din, din_q}; offset k starts at bit k of the previous word.
    always_comb begin
        din_d = din;
        s1_d  = din_q;
        case (offset_q)
            4'd1:    s1_d = {din[0],   din_q[9:1]};
            4'd2:    s1_d = {din[1:0], din_q[9:2]};
            4'd3:    s1_d = {din[2:0], din_q[9:3]};
            4'd4:    s1_d = {din[3:0], din_q[9:4]};
            4'd5:    s1_d = {din[4:0], din_q[9:5]};
            4'd6:    s1_d = {din[5:0], din_q[9:6]};
            4'd7:    s1_d = {din[6:0], din_q[9:7]};
            4'd8:    s1_d = {din[7:0], din_q[9:8]};
            4'd9:    s1_d = {din[8:0], din_q[9]};
            default: s1_d = din_q;
        endcase
    end

    tmds_word_decode u_dec (
        .q      (s1_q),
        .data   (dec_data),
        .c      (dec_c),
        .is_ctl (dec_ctl)
    );

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        run_d    = run_q;
        tmo_d    = tmo_q;
        loss_d   = loss_q;
        hold_d   = hold_q;

        // Right after an offset change stage 1 still holds old-offset words.
        if (hold_q != 2'd0) begin
            hold_d = hold_q - 2'd1;
            run_d  = '0;
        end else if (dec_ctl) begin
            if (run_q != RUN_FULL) begin
                run_d = run_q + RUN_W'(1);
            end
        end else begin
            run_d = '0;
        end

        case (state_q)
            SEARCH: begin
                loss_d = '0;
                if (run_q == RUN_FULL) begin
                    state_d = LOCKED;
                    tmo_d   = '0;
                end else if (hold_q != 2'd0) begin
                    tmo_d = tmo_q;
                end else if (tmo_q == TMO_LAST) begin
                    offset_d = next_offset(offset_q);
                    run_d    = '0;
                    tmo_d    = '0;
                    hold_d   = HOLDOFF;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            LOCKED: begin
                tmo_d = '0;
                if (run_q == RUN_FULL) begin
                    loss_d = '0;
                end else if (loss_q == LOSS_LAST) begin
                    state_d  = SEARCH;
                    offset_d = next_offset(offset_q);
                    run_d    = '0;
                    loss_d   = '0;
                    hold_d   = HOLDOFF;
                end else begin
                    loss_d = loss_q + LOSS_W'(1);
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    // Gated on the next state so the first data word after a run decodes
    // in the same cycle that locked rises.
    always_comb begin
        data_d = data_q;
        c_d    = c_q;
        de_d   = 1'b0;
        if (state_d != LOCKED) begin
            data_d = '0;
            c_d    = '0;
        end else if (dec_ctl) begin
            c_d = dec_c;
        end else begin
            data_d = dec_data;
            de_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            din_q    <= '0;
            s1_q     <= '0;
            data_q   <= '0;
            c_q      <= '0;
            de_q     <= 1'b0;
            state_q  <= SEARCH;
            offset_q <= '0;
            run_q    <= '0;
            tmo_q    <= '0;
            loss_q   <= '0;
            hold_q   <= '0;
        end else begin
            din_q    <= din_d;
            s1_q     <= s1_d;
            data_q   <= data_d;
            c_q      <= c_d;
            de_q     <= de_d;
            state_q  <= state_d;
            offset_q <= offset_d;
            run_q    <= run_d;
            tmo_q    <= tmo_d;
            loss_q   <= loss_d;
            hold_q   <= hold_d;
        end
    end

    assign data   = data_q;
    assign c      = c_q;
    assign de     = de_q;
    assign locked = (state_q == LOCKED);
    assign offset = offset_q;

`ifdef TMDS_ERR_CNT_EN
    logic [15:0] err_q, err_d;
    logic        lost;

    assign lost = (state_q == LOCKED) && (state_d == SEARCH);

    always_comb begin
        err_d = err_q;
        if (err_clr) begin
            err_d = '0;
        end else if (lost && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_cnt = err_q;
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: hand-decoded TMDS words go into an
// expected queue; a monitor pops and compares on every de=1 output.
module tb_tmds_channel_decoder;

    localparam logic [9:0] T0 = 10'b1101010100;  // c=00
    localparam logic [9:0] T1 = 10'b0010101011;  // c=01
    localparam logic [9:0] T2 = 10'b0101010100;  // c=10
    localparam logic [9:0] T3 = 10'b1010101011;  // c=11
    localparam logic [9:0] W1 = 10'b0100000000;  // -> 8'h00
    localparam logic [9:0] W2 = 10'b1111111111;  // -> 8'h00
    localparam logic [9:0] W3 = 10'b0000000000;  // -> 8'hFE
    localparam logic [9:0] W5 = 10'b0100000001;  // -> 8'h03
    localparam logic [9:0] W6 = 10'b1000001111;  // -> 8'hEE
    localparam logic [9:0] W7 = 10'b0111110000;  // -> 8'h10

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [9:0] din = '0;
    logic [7:0] data;
    logic [1:0] c;
    logic       de;
    logic       locked;
    logic [3:0] offset;
`ifdef TMDS_ERR_CNT_EN
    logic        err_clr = 1'b0;
    logic [15:0] err_cnt;
`endif

    tmds_channel_decoder dut (
        .clk    (clk),
        .resetn (resetn),
        .din    (din),
        .data   (data),
        .c      (c),
        .de     (de),
        .locked (locked),
        .offset (offset)
`ifdef TMDS_ERR_CNT_EN
        ,
        .err_clr(err_clr),
        .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int         n_pass = 0;
    int         n_total = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    bit         mon_en = 1'b0;
    int         sh = 0;
    int         cur_off = 0;
    logic [9:0] prev_ch = '0;
    logic [9:0] pat [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Sends one character, serialised so that window offset `sh` aligns.
    task automatic send(input logic [9:0] ch);
        logic [19:0] pair;
        pair = {ch, prev_ch};
        din = 10'(pair >> (10 - sh));
        prev_ch = ch;
        @(negedge clk);
    endtask

    task automatic send_push(input logic [9:0] ch, input logic [7:0] exp);
        exp_q.push_back(exp);
        send(ch);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            send(T0);
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic lose_lock();
        int n = 0;
        while (locked && n < 5000) begin
            send(W5);
            n++;
        end
        check("lock_lost", locked, 0);
    endtask

    always @(negedge clk) begin
        if (resetn && mon_en && de) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard: data 0x%0h appeared, expected no output", data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (data === mon_exp) n_pass++;
                else $display("FAIL scoreboard: data 0x%0h, expected 0x%0h", data, mon_exp);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 12; i++) pat[i] = T0;
        pat[12] = W5; pat[13] = W6; pat[14] = W7; pat[15] = W3;

        // Reset with random input
        resetn = 1'b0;
        repeat (6) begin
            @(negedge clk);
            din = 10'($urandom_range(0, 1023));
        end
        check("rst_data", data, 0);
        check("rst_c", c, 0);
        check("rst_de", de, 0);
        check("rst_locked", locked, 0);
        check("rst_offset", offset, 0);
        resetn = 1'b1;

        // Aligned stream at offset 0
        mon_en = 1'b1;
        repeat (8) send(T0);
        send_push(W1, 8'h00);
        send_push(W2, 8'h00);
        check("lock_not_yet", locked, 0);
        send_push(W5, 8'h03);
        check("lock_after_run", locked, 1);
        check("lock_offset0", offset, 0);
        send_push(W6, 8'hEE);
        repeat (4) send(T3);
        check("ctl_c3", c, 3);
        check("ctl_data_holds", data, 8'hEE);
        check("ctl_de0", de, 0);
        send_push(W7, 8'h10);
        repeat (4) send(T2);
        check("ctl_c2", c, 2);
        send_push(W3, 8'hFE);
        send_push(W7, 8'h10);
        send_push(W3, 8'hFE);
        check("data_c_holds", c, 2);
        check("data_de1", de, 1);
        repeat (4) send(T1);
        check("ctl_c1", c, 1);
        check("ctl_data_holds2", data, 8'hFE);
        repeat (4) send(T0);
        check("ctl_c0", c, 0);
        drain();
        mon_en = 1'b0;

        // Loss of lock after a long data-only stretch
        repeat (4000) send(W5);
        check("no_early_loss", locked, 1);
        repeat (110) send(W5);
        check("loss_locked", locked, 0);
        check("loss_offset", offset, 1);
        check("loss_de", de, 0);

        // Relock at offset 1, then asynchronous reset mid-stream
        sh = 1;
        repeat (14) send(T0);
        check("relock_off1", locked, 1);
        check("relock_off1_offset", offset, 1);
        repeat (3) send(W6);
        check("stream_data", data, 8'hEE);
        #2 resetn = 1'b0;
        #1;
        check("arst_locked", locked, 0);
        check("arst_offset", offset, 0);
        check("arst_de", de, 0);
        check("arst_data", data, 0);
        @(negedge clk);
        resetn = 1'b1;
        sh = 0;
        mon_en = 1'b1;
        repeat (8) send(T0);
        send_push(W6, 8'hEE);
        send_push(W2, 8'h00);
        send_push(W5, 8'h03);
        check("relock_after_rst", locked, 1);
        check("relock_rst_offset", offset, 0);
        drain();
        mon_en = 1'b0;

        // Stream shifted by 3 bits: search steps the offset until lock
        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        sh = 3;
        for (int i = 0; i < 3200; i++) begin
            send(pat[i % 16]);
            case (i + 1)
                1023: check("step_wait0", offset, 0);
                1024: check("step_to1", offset, 1);
                2049: check("step_wait1", offset, 1);
                2050: check("step_to2", offset, 2);
                3075: check("step_wait2", offset, 2);
                3076: check("step_to3", offset, 3);
                default: ;
            endcase
        end
        check("shift_locked", locked, 1);
        check("shift_offset", offset, 3);
        repeat (16) send(T0);
        mon_en = 1'b1;
        send_push(W5, 8'h03);
        send_push(W6, 8'hEE);
        send_push(W7, 8'h10);
        send_push(W3, 8'hFE);
        send_push(W1, 8'h00);
        send_push(W2, 8'h00);
        repeat (4) send(T0);
        drain();
        mon_en = 1'b0;

`ifdef TMDS_ERR_CNT_EN
        // Lock-loss counter: three losses, then a fourth with clear held
        cur_off = 3;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) err_clr = 1'b1;
            lose_lock();
            err_clr = 1'b0;
            cur_off = (cur_off + 1) % 10;
            sh = cur_off;
            repeat (14) send(T0);
            check("err_relock", locked, 1);
            if (k == 2) check("err_cnt_three", err_cnt, 3);
        end
        check("err_cnt_cleared", err_cnt, 0);
`endif

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
